// File: rtl/msg_router_pkg.sv
// Shared constants for the message routing blocks.
// Combinational only: holds no state and adds no latency.
// Backpressure: not applicable.
package msg_router_pkg;

  // Width of the bad-address drop counter and the value where it saturates.
  localparam int                    DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Increment that sticks at DROP_CNT_MAX instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/route_buffer.sv
// One-entry pipeline buffer carrying a routed message {addr, data}.
// Latency: 1 cycle from input accept to output valid.
// Backpressure: in_rdy is high when empty or when the held entry drains this cycle.
module route_buffer
  import msg_router_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         full_q, full_d;
  logic [W-1:0] dat_q,  dat_d;
  logic         in_fire, out_fire;

  // Accept into an empty slot, or into a slot being drained in the same cycle.
  always_comb begin
    in_rdy   = !reset && (!full_q || out_rdy);
    in_fire  = in_val && in_rdy;
    out_fire = full_q && out_rdy;
    full_d   = full_q;
    dat_d    = dat_q;
    if (in_fire) begin
      full_d = 1'b1;
      dat_d  = in_dat;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
  end

  // Buffer state register; reset drops any held message.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
    end
  end

  assign out_val = full_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/msg_router.sv
// Routes {addr, data} messages to one of num_outputs ports; bad addresses are counted and dropped.
// Latency: 1 cycle recv-to-send through a single-entry buffer, 1 message/cycle throughput.
// Backpressure: recv_rdy follows the ready of the port the buffered message is waiting on.
module msg_router
  import msg_router_pkg::*;
#(
  parameter int nbits       = 32,
  parameter int num_outputs = 3,
  parameter int addr_nbits  = $clog2(num_outputs)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        recv_val,
  output logic                        recv_rdy,
  input  logic [addr_nbits+nbits-1:0] recv_msg,
  output logic [num_outputs-1:0]      send_val,
  input  logic [num_outputs-1:0]      send_rdy,
  output logic [nbits-1:0]            send_msg [num_outputs],
  output logic [DROP_CNT_W-1:0]       drop_count
);

  localparam int MW = addr_nbits + nbits;

  logic [addr_nbits-1:0] recv_addr;
  logic                  addr_ok;
  logic                  buf_in_val;
  logic                  buf_val;
  logic                  buf_out_rdy;
  logic [MW-1:0]         buf_dat;
  logic [addr_nbits-1:0] buf_addr;
  logic                  drop_fire;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  // Header decode: only addresses that name a real port enter the buffer.
  assign recv_addr  = recv_msg[MW-1 -: addr_nbits];
  assign addr_ok    = ({1'b0, recv_addr} < (addr_nbits + 1)'(num_outputs));
  assign buf_in_val = recv_val && addr_ok;

  route_buffer #(
    .W (MW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .in_val  (buf_in_val),
    .in_rdy  (recv_rdy),
    .in_dat  (recv_msg),
    .out_val (buf_val),
    .out_rdy (buf_out_rdy),
    .out_dat (buf_dat)
  );

  assign buf_addr = buf_dat[MW-1 -: addr_nbits];

  // One-hot valid toward the addressed port; forced low while reset is held.
  always_comb begin
    send_val = '0;
    for (int j = 0; j < num_outputs; j++) begin
      send_val[j] = !reset && buf_val && (buf_addr == addr_nbits'(j));
    end
  end

  // The buffer drains only when the port it is waiting on is ready.
  assign buf_out_rdy = |(send_val & send_rdy);

  // Payload fans out to every port; each consumer qualifies it with its own valid.
  always_comb begin
    for (int j = 0; j < num_outputs; j++) begin
      send_msg[j] = buf_dat[nbits-1:0];
    end
  end

  // Bad-address messages are still consumed, and counted with saturation.
  always_comb begin
    drop_fire = recv_val && recv_rdy && !addr_ok;
    drop_d    = drop_q;
    if (drop_fire) begin
      drop_d = sat_inc(drop_q);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;

endmodule

// File: doc/msg_router.md
MSG_ROUTER -- requirements
Module: msg_router

Interface
REQ-001 SHALL have parameter nbits, default 32, payload width.
REQ-002 SHALL have parameter num_outputs, default 3, number of destination ports (>= 2).
REQ-003 SHALL have parameter addr_nbits, default $clog2(num_outputs), header address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port recv_val  input  1  upstream message valid.
REQ-007 SHALL have port recv_rdy  output  1  router can accept a message.
REQ-008 SHALL have port recv_msg  input  addr_nbits+nbits  message; {addr, data}, with the address in the MSBs.
REQ-009 SHALL have port send_val  output  1 per port [0:num_outputs-1]  destination valid.
REQ-010 SHALL have port send_rdy  input  1 per port [0:num_outputs-1]  destination ready.
REQ-011 SHALL have port send_msg  output  nbits per port [0:num_outputs-1]  payload, header stripped.
REQ-012 SHALL have port drop_count  output  8  saturating count of messages dropped for a bad address.

Function
REQ-013 SHALL hold one message in a buffer (buf_full, buf_addr, buf_data); accept = recv_val && recv_rdy; send fire = buf_full && send_rdy[buf_addr].
REQ-014 SHALL drive recv_rdy = !reset && (!buf_full || send_rdy[buf_addr]), giving full throughput of 1 message/cycle.
REQ-015 SHALL, on accept with addr < num_outputs, load buf_addr/buf_data and set buf_full; latency recv-to-send is exactly 1 cycle.
REQ-016 SHALL drive send_val[j] = buf_full && (buf_addr == j); at most one send_val is high in any cycle.
REQ-017 SHALL drive every send_msg[j] with buf_data; consumers qualify it with their own send_val.
REQ-018 SHALL clear buf_full on send fire when no new valid-address message is accepted in the same cycle.
REQ-019 SHALL, on simultaneous send fire and valid-address accept, replace the buffer contents and keep buf_full = 1 (no bubble).
REQ-020 SHALL hold buffer contents and send_val stable while send_rdy[buf_addr] = 0 (no message loss or reorder).
REQ-021 SHALL, on accept with addr >= num_outputs, consume the message without loading it, increment drop_count (saturating at 255), and clear buf_full if a send fire occurs in the same cycle.
REQ-022 SHALL deliver messages in acceptance order regardless of destination.

Reset
REQ-023 SHALL, on reset, set buf_full = 0 and drop_count = 0; every send_val is 0 and recv_rdy is 0 while reset is high.
REQ-024 SHALL discard any buffered message when reset is asserted mid-operation; recv_rdy = 1 in the first cycle after reset deasserts.

Structure
REQ-025 SHALL place the drop-counter width constant (8) and its saturation value in the shared package used by the arbitration/routing blocks.
REQ-026 SHALL implement the one-entry buffer as sub-module route_buffer (val/rdy in, val/rdy out, width addr_nbits+nbits); msg_router holds the decode and drop-counter logic.

Verification (nbits=32, num_outputs=3, addr_nbits=2)
REQ-027 SHALL cover basic route: recv_msg={2'd1,32'hDEADBEEF} accepted, all send_rdy=1 -> next cycle send_val[1]=1, send_msg[1]=32'hDEADBEEF, send_val[0]=send_val[2]=0.
REQ-028 SHALL cover streaming: back-to-back messages to addr 0,2,1,0 with all send_rdy=1 -> recv_rdy stays 1 and each message appears on its port on successive cycles, in order.
REQ-029 SHALL cover backpressure: message buffered for addr 2 with send_rdy[2]=0 for 3 cycles -> recv_rdy=0 and send_msg[2] stable; send_rdy[2]=1 -> delivered once, recv_rdy=1 in the same cycle.
REQ-030 SHALL cover bad address: recv_msg={2'd3,32'h1} accepted -> no send_val asserted, drop_count 0->1; 300 such messages -> drop_count=255.
REQ-031 SHALL cover reset mid-operation: message held for addr 0 with send_rdy[0]=0, then reset for 1 cycle -> send_val all 0, drop_count=0, recv_rdy=1 after reset; the old message is never delivered.
